// File: rtl/reg_file_sb_if.sv
// -----------------------------------------------------------------------------
// reg_file_sb_if
// Bundles the decode/writeback signals of the scoreboarded register file.
//
// Signals (direction as seen by the register file, i.e. the slave modport):
//   Rd_Addr_A / Rd_Addr_B   in   ADDR_W  read port addresses
//   Rd_Data_A / Rd_Data_B   out  DATA_W  read data, combinational
//   Rd_Busy_A / Rd_Busy_B   out  1       addressed register has a pending write
//   Stall                   out  1       either read port sees a busy register
//   Wr_En / Wr_Addr / Wr_Data  in        writeback strobe, address, data
//   Rsv_En / Rsv_Addr       in           reservation request and target
//   Rsv_Ack                 out  1       reservation accepted this cycle
//   Busy_Count              out  ADDR_W+1 number of busy registers
//
// Modports: master = decode/writeback side, slave = register file.
// -----------------------------------------------------------------------------
interface reg_file_sb_if #(
   parameter int unsigned DATA_W = 32'd8,
   parameter int unsigned ADDR_W = 32'd3
);

   logic [ADDR_W-1:0] Rd_Addr_A;
   logic [DATA_W-1:0] Rd_Data_A;
   logic              Rd_Busy_A;
   logic [ADDR_W-1:0] Rd_Addr_B;
   logic [DATA_W-1:0] Rd_Data_B;
   logic              Rd_Busy_B;
   logic              Stall;
   logic              Wr_En;
   logic [ADDR_W-1:0] Wr_Addr;
   logic [DATA_W-1:0] Wr_Data;
   logic              Rsv_En;
   logic [ADDR_W-1:0] Rsv_Addr;
   logic              Rsv_Ack;
   logic [ADDR_W:0]   Busy_Count;

   modport master (
      output Rd_Addr_A, Rd_Addr_B, Wr_En, Wr_Addr, Wr_Data, Rsv_En, Rsv_Addr,
      input  Rd_Data_A, Rd_Busy_A, Rd_Data_B, Rd_Busy_B, Stall, Rsv_Ack,
             Busy_Count
   );

   modport slave (
      input  Rd_Addr_A, Rd_Addr_B, Wr_En, Wr_Addr, Wr_Data, Rsv_En, Rsv_Addr,
      output Rd_Data_A, Rd_Busy_A, Rd_Data_B, Rd_Busy_B, Stall, Rsv_Ack,
             Busy_Count
   );

endinterface

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Register file with two combinational read ports, one synchronous write port
// and a per-register busy scoreboard. Decode reserves a destination register
// (marking it busy); writeback clears the busy bit when it writes the result.
// Readers use Rd_Busy_x / Stall to detect RAW hazards, and a reservation of an
// already-busy register is refused (WAW) unless it is written that same cycle.
//
// Ports:
//   Clk    in  rising-edge clock for all state
//   Reset  in  asynchronous, active-low; registers reload their own index,
//              all busy bits and Busy_Count clear
//   bus    reg_file_sb_if.slave, see the interface file for signal list
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    address width, depth = 2**ADDR_W
//   ZERO_REG  1: register 0 reads 0, is never written and never busy
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read of the register being written
//                      returns Wr_Data and not-busy in the write cycle itself,
//                      so Stall releases in the writeback cycle. When not
//                      defined, reads see the stored state until the edge.
// -----------------------------------------------------------------------------
module reg_file_sb #(
   parameter int unsigned DATA_W   = 32'd8,
   parameter int unsigned ADDR_W   = 32'd3,
   parameter bit          ZERO_REG = 1'b0
) (
   input logic         Clk,
   input logic         Reset,
   reg_file_sb_if.slave bus
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 32'd1;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // Architectural state
   logic [DATA_W-1:0] regs_r [DEPTH];
   logic [DEPTH-1:0]  busy_r;
   logic [CNT_W-1:0]  busy_count_r;

   // Next-state and handshake terms
   logic              wr_eff_s;
   logic              rsv_ack_s;
   logic              rsv_eff_s;
   logic              clr_s;
   logic [DEPTH-1:0]  wr_mask_s;
   logic [DEPTH-1:0]  rsv_mask_s;
   logic [DEPTH-1:0]  busy_next_s;
   logic [CNT_W-1:0]  busy_count_next_s;

   // Read port results
   logic [DATA_W-1:0] rd_data_a_s;
   logic [DATA_W-1:0] rd_data_b_s;
   logic              rd_busy_a_s;
   logic              rd_busy_b_s;

   // True when addr names the hardwired zero register.
   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
      return ZERO_REG && (addr == {ADDR_W{1'b0}});
   endfunction

   // One-hot decode of an address, gated by an enable.
   function automatic logic [DEPTH-1:0] onehot(input logic en,
                                               input logic [ADDR_W-1:0] addr);
      logic [DEPTH-1:0] one_v;
      one_v = {{(DEPTH-1){1'b0}}, 1'b1};
      if (en) begin
         return one_v << addr;
      end else begin
         return {DEPTH{1'b0}};
      end
   endfunction

   // Data seen by a read port: zero register first, then bypass, then storage.
   function automatic logic [DATA_W-1:0] port_data(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              wr_en,
      input logic [ADDR_W-1:0] wr_addr,
      input logic [DATA_W-1:0] wr_data
   );
      if (is_zero_reg(addr)) begin
         return {DATA_W{1'b0}};
      end else if (BYPASS && wr_en && (addr == wr_addr)) begin
         return wr_data;
      end else begin
         return stored;
      end
   endfunction

   // Busy flag seen by a read port, same precedence as the data path.
   function automatic logic port_busy(
      input logic [ADDR_W-1:0] addr,
      input logic              stored,
      input logic              wr_en,
      input logic [ADDR_W-1:0] wr_addr
   );
      if (is_zero_reg(addr)) begin
         return 1'b0;
      end else if (BYPASS && wr_en && (addr == wr_addr)) begin
         return 1'b0;
      end else begin
         return stored;
      end
   endfunction

   // Write/reserve arbitration, busy-bit next state and running count.
   always_comb begin
      wr_eff_s  = bus.Wr_En && !is_zero_reg(bus.Wr_Addr);
      // A busy target is still grantable when writeback frees it this cycle.
      rsv_ack_s = bus.Rsv_En &&
                  (is_zero_reg(bus.Rsv_Addr) ||
                   !busy_r[bus.Rsv_Addr] ||
                   (bus.Wr_En && (bus.Wr_Addr == bus.Rsv_Addr)));
      // The zero register acknowledges but never becomes busy.
      rsv_eff_s = rsv_ack_s && !is_zero_reg(bus.Rsv_Addr);
      clr_s     = wr_eff_s && busy_r[bus.Wr_Addr];
      wr_mask_s  = onehot(wr_eff_s, bus.Wr_Addr);
      rsv_mask_s = onehot(rsv_eff_s, bus.Rsv_Addr);
      // Reservation is applied after the clear so it wins on a shared address.
      busy_next_s = (busy_r & ~wr_mask_s) | rsv_mask_s;
      busy_count_next_s = busy_count_r + CNT_W'(rsv_eff_s) - CNT_W'(clr_s);
   end

   // Read ports A and B.
   always_comb begin
      rd_data_a_s = port_data(bus.Rd_Addr_A, regs_r[bus.Rd_Addr_A],
                              bus.Wr_En, bus.Wr_Addr, bus.Wr_Data);
      rd_busy_a_s = port_busy(bus.Rd_Addr_A, busy_r[bus.Rd_Addr_A],
                              bus.Wr_En, bus.Wr_Addr);
      rd_data_b_s = port_data(bus.Rd_Addr_B, regs_r[bus.Rd_Addr_B],
                              bus.Wr_En, bus.Wr_Addr, bus.Wr_Data);
      rd_busy_b_s = port_busy(bus.Rd_Addr_B, busy_r[bus.Rd_Addr_B],
                              bus.Wr_En, bus.Wr_Addr);
   end

   // Register storage: reset loads each register with its own index.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int unsigned i = 32'd0; i < DEPTH; i++) begin
            regs_r[i] <= DATA_W'(i);
         end
      end else begin
         if (wr_eff_s) begin
            regs_r[bus.Wr_Addr] <= bus.Wr_Data;
         end
      end
   end

   // Scoreboard bits and busy counter.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         busy_r       <= {DEPTH{1'b0}};
         busy_count_r <= {CNT_W{1'b0}};
      end else begin
         busy_r       <= busy_next_s;
         busy_count_r <= busy_count_next_s;
      end
   end

   assign bus.Rd_Data_A  = rd_data_a_s;
   assign bus.Rd_Busy_A  = rd_busy_a_s;
   assign bus.Rd_Data_B  = rd_data_b_s;
   assign bus.Rd_Busy_B  = rd_busy_b_s;
   assign bus.Stall      = rd_busy_a_s | rd_busy_b_s;
   assign bus.Rsv_Ack    = rsv_ack_s;
   assign bus.Busy_Count = busy_count_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (ZERO_REG=0 and ZERO_REG=1) share one
// stimulus stream and are checked against an array/popcount reference model.
module tb_reg_file_sb;

   localparam int DW = 8;
   localparam int AW = 3;

   logic Clk   = 1'b0;
   logic Reset = 1'b0;

   always #5 Clk = ~Clk;

   reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) dut0 (
      .Clk(Clk), .Reset(Reset), .bus(bus0));
   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut1 (
      .Clk(Clk), .Reset(Reset), .bus(bus1));

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model, index 0 = ZERO_REG off, index 1 = ZERO_REG on
   logic [7:0] m_mem  [2][8];
   bit         m_busy [2][8];

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] ra, input logic [2:0] rb,
                        input logic we, input logic [2:0] wa,
                        input logic [7:0] wd, input logic re,
                        input logic [2:0] rsa);
      bus0.Rd_Addr_A = ra;  bus1.Rd_Addr_A = ra;
      bus0.Rd_Addr_B = rb;  bus1.Rd_Addr_B = rb;
      bus0.Wr_En     = we;  bus1.Wr_En     = we;
      bus0.Wr_Addr   = wa;  bus1.Wr_Addr   = wa;
      bus0.Wr_Data   = wd;  bus1.Wr_Data   = wd;
      bus0.Rsv_En    = re;  bus1.Rsv_En    = re;
      bus0.Rsv_Addr  = rsa; bus1.Rsv_Addr  = rsa;
   endtask

   task automatic model_reset();
      for (int z = 0; z < 2; z++)
         for (int i = 0; i < 8; i++) begin
            m_mem[z][i]  = 8'(i);
            m_busy[z][i] = 1'b0;
         end
   endtask

   function automatic bit zreg(int z, logic [2:0] a);
      return (z == 1) && (a == 3'd0);
   endfunction

   function automatic bit wr_hit(logic [2:0] a);
      return BYP && bus0.Wr_En && (bus0.Wr_Addr == a);
   endfunction

   function automatic logic [7:0] exp_data(int z, logic [2:0] a);
      if (zreg(z, a)) return 8'h00;
      if (wr_hit(a))  return bus0.Wr_Data;
      return m_mem[z][a];
   endfunction

   function automatic bit exp_busy(int z, logic [2:0] a);
      if (zreg(z, a)) return 1'b0;
      if (wr_hit(a))  return 1'b0;
      return m_busy[z][a];
   endfunction

   function automatic bit exp_ack(int z);
      if (!bus0.Rsv_En) return 1'b0;
      if (zreg(z, bus0.Rsv_Addr)) return 1'b1;
      if (!m_busy[z][bus0.Rsv_Addr]) return 1'b1;
      return bus0.Wr_En && (bus0.Wr_Addr == bus0.Rsv_Addr);
   endfunction

   function automatic int exp_count(int z);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(m_busy[z][i]);
      return n;
   endfunction

   task automatic check_inst(input int z, input logic [7:0] da, input logic ba,
                             input logic [7:0] db, input logic bb,
                             input logic st, input logic ack,
                             input logic [3:0] cnt);
      bit eba, ebb;
      eba = exp_busy(z, bus0.Rd_Addr_A);
      ebb = exp_busy(z, bus0.Rd_Addr_B);
      check_val($sformatf("z%0d rd_data_a", z), da, exp_data(z, bus0.Rd_Addr_A));
      check_val($sformatf("z%0d rd_busy_a", z), ba, eba);
      check_val($sformatf("z%0d rd_data_b", z), db, exp_data(z, bus0.Rd_Addr_B));
      check_val($sformatf("z%0d rd_busy_b", z), bb, ebb);
      check_val($sformatf("z%0d stall", z), st, eba | ebb);
      check_val($sformatf("z%0d rsv_ack", z), ack, exp_ack(z));
      check_val($sformatf("z%0d busy_count", z), cnt, exp_count(z));
   endtask

   // Let inputs settle, then compare both instances with the model.
   task automatic settle();
      #1;
      check_inst(0, bus0.Rd_Data_A, bus0.Rd_Busy_A, bus0.Rd_Data_B,
                 bus0.Rd_Busy_B, bus0.Stall, bus0.Rsv_Ack, bus0.Busy_Count);
      check_inst(1, bus1.Rd_Data_A, bus1.Rd_Busy_A, bus1.Rd_Data_B,
                 bus1.Rd_Busy_B, bus1.Stall, bus1.Rsv_Ack, bus1.Busy_Count);
   endtask

   // Apply the current inputs to the model, then advance past the edge.
   task automatic tick();
      if (Reset) begin
         for (int z = 0; z < 2; z++) begin
            bit ack;
            ack = exp_ack(z);
            if (bus0.Wr_En && !zreg(z, bus0.Wr_Addr)) begin
               m_mem[z][bus0.Wr_Addr]  = bus0.Wr_Data;
               m_busy[z][bus0.Wr_Addr] = 1'b0;
            end
            if (ack && !zreg(z, bus0.Rsv_Addr))
               m_busy[z][bus0.Rsv_Addr] = 1'b1;
         end
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      drive(3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      model_reset();
      repeat (2) @(posedge Clk);
      #1;

      // Reset state on both ports, reads live during reset
      for (int i = 0; i < 8; i++) begin
         drive(3'(i), 3'(7 - i), 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
         settle();
         check_val("reset_rd_a_index", bus0.Rd_Data_A, 32'(i));
      end
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;

      // Reserve r3, then retry while busy
      drive(3'd3, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
      settle();
      check_val("rsv3_first_ack", bus0.Rsv_Ack, 32'd1);
      tick();
      settle();
      check_val("rsv3_retry_ack", bus0.Rsv_Ack, 32'd0);
      check_val("rsv3_stall", bus0.Stall, 32'd1);
      check_val("rsv3_count", bus0.Busy_Count, 32'd1);
      tick();

      // Writeback r3 while port A reads it
      drive(3'd3, 3'd0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0);
      settle();
      check_val("wb3_same_cycle_data", bus0.Rd_Data_A, BYP ? 32'hA5 : 32'h03);
      check_val("wb3_same_cycle_stall", bus0.Stall, BYP ? 32'd0 : 32'd1);
      tick();
      drive(3'd3, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      settle();
      check_val("wb3_next_data", bus0.Rd_Data_A, 32'hA5);
      check_val("wb3_next_count", bus0.Busy_Count, 32'd0);

      // r5 busy, then write and re-reserve in one cycle
      drive(3'd5, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5);
      settle();
      tick();
      drive(3'd5, 3'd0, 1'b1, 3'd5, 8'h11, 1'b1, 3'd5);
      settle();
      check_val("wr_rsv5_ack", bus0.Rsv_Ack, 32'd1);
      tick();
      drive(3'd5, 3'd5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      settle();
      check_val("wr_rsv5_data", bus0.Rd_Data_A, 32'h11);
      check_val("wr_rsv5_busy", bus0.Rd_Busy_A, 32'd1);
      check_val("wr_rsv5_count", bus0.Busy_Count, 32'd1);
      // Release r5
      drive(3'd5, 3'd0, 1'b1, 3'd5, 8'h22, 1'b0, 3'd0);
      settle();
      tick();

      // Zero register: write 0xFF and reserve r0
      drive(3'd0, 3'd0, 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0);
      settle();
      check_val("zr_rsv_ack", bus1.Rsv_Ack, 32'd1);
      tick();
      drive(3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      settle();
      check_val("zr_data", bus1.Rd_Data_A, 32'h00);
      check_val("zr_busy", bus1.Rd_Busy_A, 32'd0);
      check_val("zr_count", bus1.Busy_Count, 32'd0);
      check_val("nz_r0_data", bus0.Rd_Data_A, 32'hFF);
      drive(3'd0, 3'd0, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0);
      settle();
      tick();

      // Reserve r1, r2, r4 after writing r2, then reset mid-cycle
      drive(3'd2, 3'd0, 1'b1, 3'd2, 8'h77, 1'b0, 3'd0);
      settle();
      tick();
      drive(3'd1, 3'd4, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1);
      settle();
      tick();
      drive(3'd1, 3'd4, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
      settle();
      tick();
      drive(3'd2, 3'd4, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4);
      settle();
      tick();
      drive(3'd2, 3'd4, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      settle();
      check_val("pre_reset_count", bus0.Busy_Count, 32'd3);
      #2;
      Reset = 1'b0;
      model_reset();
      settle();
      check_val("async_rst_r2", bus0.Rd_Data_A, 32'h02);
      check_val("async_rst_busy", bus0.Rd_Busy_B, 32'd0);
      check_val("async_rst_count", bus0.Busy_Count, 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)),
               8'($urandom), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)));
         settle();
         tick();
      end

      // Final sweep of stored contents
      for (int i = 0; i < 8; i++) begin
         drive(3'(i), 3'(7 - i), 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
         settle();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the 8×8 single-write register file. It provides two asynchronous read ports, one synchronous write port and a per-register scoreboard (busy bit) with a reservation handshake. The scoreboard lets the multi-cycle datapath detect RAW hazards (stall) and block WAW re-reservation. It sits between the decode stage (reads, reservations) and the writeback stage (writes).

## Interface
Parameters:
- DATA_W, 8, width of each register.
- ADDR_W, 3, address width; depth is 2**ADDR_W registers.
- ZERO_REG, 0, when 1 register 0 is hardwired to zero, never written, never busy.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Rd_Addr_A  in  ADDR_W  read port A address.
- Rd_Data_A  out  DATA_W  read port A data, combinational.
- Rd_Busy_A  out  1  register at Rd_Addr_A has a pending write.
- Rd_Addr_B / Rd_Data_B / Rd_Busy_B  in/out/out  ADDR_W/DATA_W/1  read port B, identical to port A.
- Stall  out  1  Rd_Busy_A | Rd_Busy_B.
- Wr_En  in  1  write strobe.
- Wr_Addr  in  ADDR_W  write address.
- Wr_Data  in  DATA_W  write data.
- Rsv_En  in  1  request to mark Rsv_Addr busy.
- Rsv_Addr  in  ADDR_W  register to reserve.
- Rsv_Ack  out  1  reservation accepted this cycle (combinational).
- Busy_Count  out  ADDR_W+1  number of busy registers.

## Operation
- Reset asserted (Reset=0): register i loads i mod 2**DATA_W (register 0 loads 0). All busy bits, and therefore Busy_Count, go to 0. Reads stay combinational during reset.
- Write: on a rising edge with Wr_En=1, reg[Wr_Addr] <= Wr_Data and busy[Wr_Addr] <= 0. Writing a non-busy register is legal, and its busy bit stays 0.
- Reservation: Rsv_Ack = Rsv_En & (~busy[Rsv_Addr] | (Wr_En & Wr_Addr==Rsv_Addr)). On ack, busy[Rsv_Addr] <= 1 at the edge.
- Rsv_En with busy target and no same-cycle write to it: Rsv_Ack=0 and no state change. The requester must hold Rsv_En until ack.
- Same-cycle write and reserve of one address: the data is written and busy ends at 1, because the reservation wins.
- ZERO_REG=1 and address 0:
  - Rd_Data reads 0 and Rd_Busy reads 0.
  - Writes are ignored.
  - Rsv_Ack=1 whenever Rsv_En, but busy is not set.
- Busy_Count is registered. It updates at the same edge as the busy bits by (+1 on accepted effective reserve) (−1 on write clearing a set bit). It never exceeds 2**ADDR_W.
- Both read ports may address the same register, or the write address, in any cycle.

## Timing
- Read latency 0: Rd_Data and Rd_Busy are combinational from address and current state.
- Written data is visible on reads from the cycle after the write edge; for the same cycle, see Configuration.
- A reservation accepted in cycle N makes Rd_Busy=1 from cycle N+1.
- A write in cycle N makes Rd_Busy=0 from cycle N+1. Same cycle: see Configuration.
- Rsv_Ack and Stall are combinational, with no registered handshake.
- Reset mid-operation clears pending reservations immediately. Any write in flight that cycle is lost.

## Configuration
REGFILE_BYPASS_EN:
- Defined: a read port whose address equals Wr_Addr while Wr_En=1 returns Wr_Data and Rd_Busy=0 in that same cycle. Stall deasserts in the writeback cycle.
- Not defined: a read port returns the stored value and stored busy bit until the edge, so Stall releases one cycle later.
- The ZERO_REG rule overrides bypass for address 0.

## Test plan
- Reset, then read addresses 0..7 on both ports -> Rd_Data = 0..7, all Rd_Busy=0, Busy_Count=0.
- Reserve r3 (Rsv_Ack=1) -> next cycle Rd_Busy_A(3)=1, Stall=1, Busy_Count=1. Second Rsv_En on r3 -> Rsv_Ack=0, Busy_Count stays 1.
- Write r3=0xA5 with Rd_Addr_A=3 in the same cycle:
  - With REGFILE_BYPASS_EN -> Rd_Data_A=0xA5, Stall=0 that cycle.
  - Without it -> old value 0x03 and Stall=1 that cycle.
  - Either way -> 0xA5 and Busy_Count=0 next cycle.
- Write r5=0x11 and Rsv_En r5 in the same cycle while r5 is busy -> Rsv_Ack=1. Next cycle r5=0x11, busy=1, Busy_Count unchanged.
- ZERO_REG=1: write r0=0xFF and reserve r0 -> Rd_Data(0)=0, Rd_Busy=0, Busy_Count=0.
- Reserve r1, r2 and r4, then pulse Reset low mid-cycle -> busy bits clear and registers reload to index values immediately, asynchronously.
